writeback_unit: RTL and testbench
=================================

Name: writeback_unit

Overview:
Parametrised, buffered writeback stage. It accepts completed instructions from memory-stage over a valid/ready handshake and queues them in a small FIFO. It retires one entry per cycle to the register file, CPSR or PC as registered single-cycle write strobes. Adds over the previous generation: configurable widths, back-pressure from the register file, flush, illegal-op detection and a retire counter.

Parameters:
DATA_W, 32, width of register, result, memory, CPSR and PC values
REG_ADDR_W, 4, register number width (2**REG_ADDR_W architectural registers)
DEPTH, 4, FIFO entries; power of two, >= 2
CNT_W, 16, retire counter width

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
in_valid  in  1  memory-stage entry valid
in_ready  out  1  FIFO can accept; equals !full (combinational from state)
in_op  in  4  one-hot op class {ld, jmp, cmp, alu} = bits [3:0]
in_rd  in  REG_ADDR_W  destination register
in_result  in  DATA_W  ALU result
in_mem_val  in  DATA_W  load data
in_md  in  DATA_W  branch target
in_cpsr  in  DATA_W  flags from compare
rf_busy  in  1  register-file port unavailable this cycle; blocks pop
flush  in  1  discard all queued entries
reg_write_en  out  1  register write strobe
reg_num  out  REG_ADDR_W  register number
reg_value  out  DATA_W  register data
cpsr_write_en  out  1  CPSR write strobe
cpsr_out  out  DATA_W  CPSR data
pc_write_en  out  1  PC write strobe
pc_out  out  DATA_W  PC data
retire_count  out  CNT_W  retired-instruction count, wraps
err_illegal  out  1  sticky: an entry with non-one-hot in_op was seen

Behaviour:
- Reset (async, rst=1): FIFO empty, in_ready=1. All *_write_en=0. reg_num, reg_value, cpsr_out, pc_out, retire_count all 0. err_illegal=0. Reset mid-stream drops all queued entries.
- Push: on a rising edge with in_valid & in_ready & !flush. An entry whose in_op is not exactly one-hot (zero or >1 bits set) is not stored; instead err_illegal is set at that edge. err_illegal clears only on reset.
- Pop: on a rising edge with FIFO non-empty & !rf_busy & !flush. The head is removed and decoded into registered outputs at the same edge:
  - alu: reg_write_en=1, reg_num=rd, reg_value=result
  - ld: reg_write_en=1, reg_num=rd, reg_value=mem_val
  - cmp: cpsr_write_en=1, cpsr_out=cpsr
  - jmp: pc_write_en=1, pc_out=md
- Exactly one strobe per pop. On every edge without a pop, all strobes are 0. Data outputs hold their last value.
- Latency: entry pushed at edge N into an empty FIFO with rf_busy=0 gives its strobe high for the cycle after edge N+1. Sustained throughput is 1 entry/cycle.
- Push and pop on the same edge are allowed when not full; occupancy is unchanged. When full, in_ready=0 even if a pop occurs that cycle.
- rf_busy=1 stalls all pops, including cmp and jmp, to preserve program order. The FIFO fills and in_ready then drops.
- flush=1 (synchronous): empties the FIFO and suppresses both push and pop that edge. Strobes are 0 next cycle. Flush has priority over everything except reset.
- retire_count increments by 1 on each pop and wraps from 2**CNT_W-1 to 0. It is not changed by flush or illegal drops.
- Pointers are log2(DEPTH) bits wide. Full and empty are distinguished by an occupancy count of width log2(DEPTH)+1.

Test Plan:
- Reset then push alu {rd=3, result=0xDEADBEEF} at edge 1 -> reg_write_en=1, reg_num=3, reg_value=0xDEADBEEF for exactly the cycle after edge 2. retire_count=1.
- Back-to-back push of alu, cmp {cpsr=0x80000000}, jmp {md=0x100}, ld {rd=5, mem_val=0x55}, one per cycle -> four consecutive single strobes in that order with those values. retire_count=4.
- Hold rf_busy=1 and push 5 alu entries (DEPTH=4) -> in_ready=0 after 4 accepted, no strobes. Release rf_busy -> 4 strobes in order, then in_ready=1.
- Push in_op=4'b0011 -> no strobe, err_illegal=1 and stays 1. retire_count unchanged. A following valid entry retires normally.
- Queue 3 entries with rf_busy=1, assert flush one cycle -> no strobes ever appear for them. The FIFO is empty and the next push retires with 2-edge latency.
- Preload retire_count to 0xFFFF (CNT_W=16) via 65535 retirements, then one more -> retire_count=0x0000. Assert rst mid-stream -> all outputs 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/writeback_unit.sv
// Buffered writeback stage: queues completed instructions in a small FIFO and
// retires one per cycle as registered register-file / CPSR / PC write strobes.
module writeback_unit #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 4,
  parameter int DEPTH      = 4,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [3:0]            in_op,
  input  logic [REG_ADDR_W-1:0] in_rd,
  input  logic [DATA_W-1:0]     in_result,
  input  logic [DATA_W-1:0]     in_mem_val,
  input  logic [DATA_W-1:0]     in_md,
  input  logic [DATA_W-1:0]     in_cpsr,
  input  logic                  rf_busy,
  input  logic                  flush,
  output logic                  reg_write_en,
  output logic [REG_ADDR_W-1:0] reg_num,
  output logic [DATA_W-1:0]     reg_value,
  output logic                  cpsr_write_en,
  output logic [DATA_W-1:0]     cpsr_out,
  output logic                  pc_write_en,
  output logic [DATA_W-1:0]     pc_out,
  output logic [CNT_W-1:0]      retire_count,
  output logic                  err_illegal
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  typedef enum logic [1:0] {K_ALU, K_CMP, K_JMP, K_LD} kind_e;

  // Only the one data word the op class needs is kept per entry.
  typedef struct packed {
    kind_e                 kind;
    logic [REG_ADDR_W-1:0] rd;
    logic [DATA_W-1:0]     value;
  } entry_t;

  entry_t           mem [DEPTH];
  entry_t           in_entry;
  entry_t           head;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             full;
  logic             empty;
  logic             op_onehot;
  logic             accept;
  logic             push;
  logic             pop;
  logic             illegal;

  assign full      = (count == FULL_CNT);
  assign empty     = (count == '0);
  assign in_ready  = !full;
  assign op_onehot = (in_op != 4'd0) && ((in_op & (in_op - 4'd1)) == 4'd0);
  assign accept    = in_valid && !full && !flush;
  assign push      = accept && op_onehot;
  assign illegal   = accept && !op_onehot;
  assign pop       = !empty && !rf_busy && !flush;
  assign head      = mem[rd_ptr];

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    in_entry.kind  = K_ALU;
    in_entry.rd    = in_rd;
    in_entry.value = in_result;
    if (in_op[3]) begin
      in_entry.kind  = K_LD;
      in_entry.value = in_mem_val;
    end else if (in_op[2]) begin
      in_entry.kind  = K_JMP;
      in_entry.value = in_md;
    end else if (in_op[1]) begin
      in_entry.kind  = K_CMP;
      in_entry.value = in_cpsr;
    end
  end

  // NOTE: storage has no reset; occupancy alone decides which entries are live.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_entry;
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_illegal <= 1'b0;
    end else if (illegal) begin
      err_illegal <= 1'b1;
    end
  end

  // Strobes are single-cycle; data outputs hold their last written value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      reg_write_en  <= 1'b0;
      cpsr_write_en <= 1'b0;
      pc_write_en   <= 1'b0;
      reg_num       <= '0;
      reg_value     <= '0;
      cpsr_out      <= '0;
      pc_out        <= '0;
      retire_count  <= '0;
    end else begin
      reg_write_en  <= 1'b0;
      cpsr_write_en <= 1'b0;
      pc_write_en   <= 1'b0;
      if (pop) begin
        retire_count <= retire_count + CNT_W'(1);
        unique case (head.kind)
          K_ALU, K_LD: begin
            reg_write_en <= 1'b1;
            reg_num      <= head.rd;
            reg_value    <= head.value;
          end
          K_CMP: begin
            cpsr_write_en <= 1'b1;
            cpsr_out      <= head.value;
          end
          K_JMP: begin
            pc_write_en <= 1'b1;
            pc_out      <= head.value;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_writeback_unit.sv
// Self-checking bench for writeback_unit: directed scenarios with literal
// expectations plus randomized traffic checked against a queue-based model.
module tb_writeback_unit;

  localparam int DATA_W     = 32;
  localparam int REG_ADDR_W = 4;
  localparam int DEPTH      = 4;
  localparam int CNT_W      = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_op;
  logic [3:0]  in_rd;
  logic [31:0] in_result;
  logic [31:0] in_mem_val;
  logic [31:0] in_md;
  logic [31:0] in_cpsr;
  logic        rf_busy;
  logic        flush;
  logic        reg_write_en;
  logic [3:0]  reg_num;
  logic [31:0] reg_value;
  logic        cpsr_write_en;
  logic [31:0] cpsr_out;
  logic        pc_write_en;
  logic [31:0] pc_out;
  logic [15:0] retire_count;
  logic        err_illegal;

  always #5 clk = ~clk;

  writeback_unit #(
    .DATA_W(DATA_W), .REG_ADDR_W(REG_ADDR_W), .DEPTH(DEPTH), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_rd(in_rd),
    .in_result(in_result), .in_mem_val(in_mem_val), .in_md(in_md), .in_cpsr(in_cpsr),
    .rf_busy(rf_busy), .flush(flush),
    .reg_write_en(reg_write_en), .reg_num(reg_num), .reg_value(reg_value),
    .cpsr_write_en(cpsr_write_en), .cpsr_out(cpsr_out),
    .pc_write_en(pc_write_en), .pc_out(pc_out),
    .retire_count(retire_count), .err_illegal(err_illegal)
  );

  // Reference model: an in-order queue of (op bit index, rd, selected data).
  typedef struct {
    int          kind;
    logic [3:0]  rd;
    logic [31:0] value;
  } ent_t;

  ent_t        q[$];
  logic        m_reg_we, m_cpsr_we, m_pc_we, m_err;
  logic [3:0]  m_reg_num;
  logic [31:0] m_reg_value, m_cpsr, m_pc;
  logic [15:0] m_cnt;
  bit          cmp_en = 1'b0;
  int          total = 0;
  int          bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_reg_we = 0; m_cpsr_we = 0; m_pc_we = 0; m_err = 0;
    m_reg_num = 0; m_reg_value = 0; m_cpsr = 0; m_pc = 0; m_cnt = 0;
  endtask

  // One clock edge worth of behaviour, from the pre-edge inputs.
  task automatic model_step();
    bit   take, retire;
    ent_t e;
    take   = in_valid && (q.size() < DEPTH) && !flush;
    retire = (q.size() != 0) && !rf_busy && !flush;
    m_reg_we = 0; m_cpsr_we = 0; m_pc_we = 0;
    if (flush) begin
      q.delete();
      return;
    end
    if (retire) begin
      e = q.pop_front();
      m_cnt++;
      case (e.kind)
        1:       begin m_cpsr_we = 1; m_cpsr = e.value; end
        2:       begin m_pc_we = 1; m_pc = e.value; end
        default: begin m_reg_we = 1; m_reg_num = e.rd; m_reg_value = e.value; end
      endcase
    end
    if (take) begin
      if ($countones(in_op) == 1) begin
        e.kind = 0;
        for (int b = 0; b < 4; b++) if (in_op[b]) e.kind = b;
        e.rd    = in_rd;
        e.value = (e.kind == 0) ? in_result : (e.kind == 1) ? in_cpsr :
                  (e.kind == 2) ? in_md : in_mem_val;
        q.push_back(e);
      end else begin
        m_err = 1;
      end
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en && !rst) begin
      check("in_ready",      in_ready,      q.size() < DEPTH);
      check("reg_write_en",  reg_write_en,  m_reg_we);
      check("reg_num",       reg_num,       m_reg_num);
      check("reg_value",     reg_value,     m_reg_value);
      check("cpsr_write_en", cpsr_write_en, m_cpsr_we);
      check("cpsr_out",      cpsr_out,      m_cpsr);
      check("pc_write_en",   pc_write_en,   m_pc_we);
      check("pc_out",        pc_out,        m_pc);
      check("retire_count",  retire_count,  m_cnt);
      check("err_illegal",   err_illegal,   m_err);
    end
  end

  task automatic drive(input bit v, input logic [3:0] op, input logic [3:0] rd,
                       input logic [31:0] res, input logic [31:0] mv, input logic [31:0] md,
                       input logic [31:0] cp, input bit busy, input bit fl);
    in_valid = v; in_op = op; in_rd = rd;
    in_result = res; in_mem_val = mv; in_md = md; in_cpsr = cp;
    rf_busy = busy; flush = fl;
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic idle(input bit busy, input int n);
    for (int i = 0; i < n; i++) begin
      drive(0, 4'b0001, 4'd0, 32'd0, 32'd0, 32'd0, 32'd0, busy, 0);
      cycle();
    end
  endtask

  // Unused data fields carry distinct decoys so a wrong field selection shows.
  task automatic push_op(input logic [3:0] op, input logic [3:0] rd, input logic [31:0] val,
                         input bit busy);
    drive(1, op, rd,
          (op == 4'b0001) ? val : 32'hA1A1_0001,
          (op == 4'b1000) ? val : 32'hB2B2_0002,
          (op == 4'b0100) ? val : 32'hC3C3_0003,
          (op == 4'b0010) ? val : 32'hD4D4_0004,
          busy, 0);
    cycle();
  endtask

  initial begin
    logic [3:0] op;
    rst = 1'b1;
    drive(0, 4'b0001, 4'd0, 32'd0, 32'd0, 32'd0, 32'd0, 0, 0);
    model_reset();
    #3;
    check("reset in_ready",     in_ready, 1);
    check("reset reg_write_en", reg_write_en, 0);
    check("reset retire_count", retire_count, 0);
    check("reset err_illegal",  err_illegal, 0);
    @(negedge clk);
    rst = 1'b0;
    cmp_en = 1'b1;

    // Two-edge latency of a single alu entry.
    push_op(4'b0001, 4'd3, 32'hDEAD_BEEF, 0);
    check("lat strobe early", reg_write_en, 0);
    idle(0, 1);
    check("lat reg_write_en", reg_write_en, 1);
    check("lat reg_num",      reg_num, 3);
    check("lat reg_value",    reg_value, 32'hDEAD_BEEF);
    check("lat retire_count", retire_count, 1);
    idle(0, 1);
    check("lat strobe single", reg_write_en, 0);

    // Back-to-back alu, cmp, jmp, ld.
    push_op(4'b0001, 4'd1, 32'h0000_0011, 0);
    push_op(4'b0010, 4'd0, 32'h8000_0000, 0);
    check("b2b alu value", reg_value, 32'h11);
    push_op(4'b0100, 4'd0, 32'h0000_0100, 0);
    check("b2b cpsr", cpsr_out, 32'h8000_0000);
    push_op(4'b1000, 4'd5, 32'h0000_0055, 0);
    check("b2b pc", pc_out, 32'h100);
    idle(0, 1);
    check("b2b ld num",   reg_num, 5);
    check("b2b ld value", reg_value, 32'h55);
    check("b2b count",    retire_count, 5);
    idle(0, 1);

    // Back-pressure fills the FIFO.
    for (int i = 0; i < 5; i++) push_op(4'b0001, 4'(i), 32'h1000 + 32'(i), 1);
    check("full in_ready", in_ready, 0);
    idle(1, 2);
    idle(0, 1);
    check("drain first", reg_value, 32'h1000);
    idle(0, 4);
    check("drain in_ready", in_ready, 1);
    check("drain count", retire_count, 9);

    // Illegal op is dropped and sticky.
    drive(1, 4'b0011, 4'd2, 32'h1, 32'h2, 32'h3, 32'h4, 0, 0);
    cycle();
    check("illegal err", err_illegal, 1);
    idle(0, 1);
    check("illegal no strobe", reg_write_en, 0);
    push_op(4'b0001, 4'd6, 32'h66, 0);
    idle(0, 1);
    check("after illegal value", reg_value, 32'h66);
    check("after illegal err",   err_illegal, 1);

    // Flush discards queued entries.
    for (int i = 0; i < 3; i++) push_op(4'b0001, 4'd9, 32'h9000 + 32'(i), 1);
    drive(0, 4'b0001, 4'd0, 32'd0, 32'd0, 32'd0, 32'd0, 1, 1);
    cycle();
    idle(0, 3);
    check("flush no strobe", reg_write_en, 0);
    check("flush count", retire_count, 10);
    push_op(4'b0001, 4'd7, 32'h77, 0);
    idle(0, 1);
    check("post flush value", reg_value, 32'h77);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      op = ($urandom_range(99) < 85) ? 4'(4'b0001 << $urandom_range(3)) : 4'($urandom_range(15));
      drive($urandom_range(99) < 70, op, 4'($urandom_range(15)),
            $urandom, $urandom, $urandom, $urandom,
            $urandom_range(99) < 30, $urandom_range(99) < 3);
      cycle();
    end

    // Asynchronous reset mid-stream.
    push_op(4'b0001, 4'd4, 32'hFACE_F00D, 1);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    check("async reg_value",    reg_value, 0);
    check("async reg_num",      reg_num, 0);
    check("async retire_count", retire_count, 0);
    check("async err_illegal",  err_illegal, 0);
    check("async in_ready",     in_ready, 1);
    check("async cpsr_out",     cpsr_out, 0);
    check("async pc_out",       pc_out, 0);
    @(negedge clk);
    rst = 1'b0;
    idle(0, 2);
    check("post reset no strobe", reg_write_en, 0);

    // Retire counter wrap.
    for (int i = 0; i < 65535; i++) push_op(4'b0001, 4'd1, 32'(i), 0);
    idle(0, 2);
    check("count max", retire_count, 16'hFFFF);
    push_op(4'b0001, 4'd1, 32'h1, 0);
    idle(0, 2);
    check("count wrap", retire_count, 16'h0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
